// File: rtl/parity_pkg.sv
// Shared constants and width helper for the parity generator.
package parity_pkg;

    localparam int PARITY_DEFAULT_WIDTH = 4;

    // Bits needed to hold a population count of 0..width without overflow.
    function automatic int count_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/parity_tree.sv
// Combinational balanced-tree XOR reduction and population count.
// Latency 0 (pure logic); no backpressure.
module parity_tree
    import parity_pkg::*;
#(
    parameter int WIDTH = PARITY_DEFAULT_WIDTH,
    parameter int CW    = count_width(WIDTH)
) (
    input  logic [WIDTH-1:0] in,
    output logic             parity,
    output logic [CW-1:0]    count
);

    // Leaves are padded with zeros up to a power of two so every level halves cleanly.
    localparam int LEVELS = (WIDTH > 1) ? $clog2(WIDTH) : 0;
    localparam int LEAVES = 1 << LEVELS;

    for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
        localparam int N = LEAVES >> l;

        logic [CW-1:0] cnt [N];
        logic          par [N];

        for (genvar n = 0; n < N; n++) begin : g_node
            if (l == 0) begin : g_leaf
                if (n < WIDTH) begin : g_data
                    assign cnt[n] = CW'(in[n]);
                    assign par[n] = in[n];
                end else begin : g_pad
                    assign cnt[n] = '0;
                    assign par[n] = 1'b0;
                end
            end else begin : g_join
                // Partial sums never exceed WIDTH, so CW bits always suffice.
                assign cnt[n] = g_lvl[l-1].cnt[2*n] + g_lvl[l-1].cnt[2*n+1];
                assign par[n] = g_lvl[l-1].par[2*n] ^ g_lvl[l-1].par[2*n+1];
            end
        end
    end

    assign count  = g_lvl[LEVELS].cnt[0];
    assign parity = g_lvl[LEVELS].par[0];

endmodule

// File: rtl/parity.sv
// Registered even/odd parity bit and ones count of the word sampled each clk edge.
// Latency 1 clk; no backpressure, a new word is accepted on every edge.
module parity
    import parity_pkg::*;
#(
    parameter int WIDTH = PARITY_DEFAULT_WIDTH,
    parameter int ODD   = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [WIDTH-1:0]              in,
    output logic                          out,
    output logic [count_width(WIDTH)-1:0] ones_count
);

    localparam int   CW      = count_width(WIDTH);
    localparam logic ODD_BIT = (ODD != 0);

    logic          tree_parity;
    logic [CW-1:0] tree_count;

    parity_tree #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_tree (
        .in     (in),
        .parity (tree_parity),
        .count  (tree_count)
    );

    // Reset values keep out == ones_count[0] ^ ODD true from the first edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            out        <= ODD_BIT;
            ones_count <= '0;
        end else begin
            out        <= tree_parity ^ ODD_BIT;
            ones_count <= tree_count;
        end
    end

endmodule

// File: tb/tb_parity.sv
module tb_parity;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] in4 = 4'b0000;
    logic [7:0] in8 = 8'h00;

    logic       out_e, out_o, out_w;
    logic [2:0] cnt_e, cnt_o;
    logic [3:0] cnt_w;

    int tests = 0;
    int fails = 0;
    bit inv_on = 1'b0;

    parity #(.WIDTH(4), .ODD(0)) dut_even (
        .clk(clk), .rst(rst), .in(in4), .out(out_e), .ones_count(cnt_e)
    );
    parity #(.WIDTH(4), .ODD(1)) dut_odd (
        .clk(clk), .rst(rst), .in(in4), .out(out_o), .ones_count(cnt_o)
    );
    parity #(.WIDTH(8), .ODD(0)) dut_wide (
        .clk(clk), .rst(rst), .in(in8), .out(out_w), .ones_count(cnt_w)
    );

    always #5 clk = ~clk;

    // out must equal ones_count[0] ^ ODD on every cycle, including during reset.
    always @(negedge clk) begin
        if (inv_on) begin
            tests++;
            if (out_e !== (cnt_e[0] ^ 1'b0) || out_o !== (cnt_o[0] ^ 1'b1) || out_w !== cnt_w[0]) begin
                fails++;
                $display("FAIL invariant: even %b/%0d odd %b/%0d wide %b/%0d, need out == count[0]^ODD",
                         out_e, cnt_e, out_o, cnt_o, out_w, cnt_w);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check4(input string name, input logic exp_e, input logic exp_o, input logic [2:0] exp_c);
        // inline comparison of both width-4 instances
        tests++;
        if (out_e !== exp_e || cnt_e !== exp_c || out_o !== exp_o || cnt_o !== exp_c) begin
            fails++;
            $display("FAIL %s: got even out=%b cnt=%0d odd out=%b cnt=%0d, need even out=%b odd out=%b cnt=%0d",
                     name, out_e, cnt_e, out_o, cnt_o, exp_e, exp_o, exp_c);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in4 = 4'b1111;
        in8 = 8'hFF;
        for (int i = 0; i < 2; i++) begin
            step();
            inv_on = 1'b1;
            check4($sformatf("reset_cycle%0d", i), 1'b0, 1'b1, 3'd0);
            tests++;
            if (out_w !== 1'b0 || cnt_w !== 4'd0) begin
                fails++;
                $display("FAIL reset_wide%0d: out=%b cnt=%0d, need out=0 cnt=0", i, out_w, cnt_w);
            end
        end
    endtask

    task automatic test_sweep();
        // hand-computed popcounts of 0..15
        int exp_cnt [16] = '{0, 1, 1, 2, 1, 2, 2, 3, 1, 2, 2, 3, 2, 3, 3, 4};
        logic [2:0] c;
        rst = 1'b0;
        for (int v = 0; v < 16; v++) begin
            in4 = 4'(v);
            step();
            c = 3'(exp_cnt[v]);
            check4($sformatf("sweep_%b", 4'(v)), c[0], ~c[0], c);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] vec [3] = '{4'b1010, 4'b0100, 4'b1101};
        logic       ep  [3] = '{1'b0, 1'b1, 1'b1};
        logic [2:0] ec  [3] = '{3'd2, 3'd1, 3'd3};
        rst = 1'b0;
        in4 = 4'b1111;
        step();
        for (int i = 0; i < 3; i++) begin
            in4 = vec[i];
            // before the edge the previous word's result must still be showing
            #1;
            if (i == 0) check4("b2b_lag", 1'b0, 1'b1, 3'd4);
            step();
            check4($sformatf("b2b_%b", vec[i]), ep[i], ~ep[i], ec[i]);
        end
    endtask

    task automatic test_hold();
        rst = 1'b0;
        in4 = 4'b0111;
        step();
        check4("hold_base", 1'b1, 1'b0, 3'd3);
        in4 = 4'b0000; #1;
        in4 = 4'b1111; #1;
        in4 = 4'b0001; #1;
        check4("hold_glitch", 1'b1, 1'b0, 3'd3);
    endtask

    task automatic test_mid_reset();
        rst = 1'b0;
        in4 = 4'b0011;
        step();
        check4("midrst_pre", 1'b0, 1'b1, 3'd2);
        rst = 1'b1;
        in4 = 4'b0111;
        step();
        check4("midrst_on", 1'b0, 1'b1, 3'd0);
        rst = 1'b0;
        in4 = 4'b0001;
        step();
        check4("midrst_after", 1'b1, 1'b0, 3'd1);
    endtask

    task automatic test_wide();
        rst = 1'b0;
        in8 = 8'hFF;
        step();
        tests++;
        if (out_w !== 1'b0 || cnt_w !== 4'd8) begin
            fails++;
            $display("FAIL wide_FF: out=%b cnt=%0d, need out=0 cnt=8", out_w, cnt_w);
        end
        in8 = 8'h80;
        step();
        tests++;
        if (out_w !== 1'b1 || cnt_w !== 4'd1) begin
            fails++;
            $display("FAIL wide_80: out=%b cnt=%0d, need out=1 cnt=1", out_w, cnt_w);
        end
        in8 = 8'hB6;
        step();
        tests++;
        if (out_w !== 1'b1 || cnt_w !== 4'd5) begin
            fails++;
            $display("FAIL wide_B6: out=%b cnt=%0d, need out=1 cnt=5", out_w, cnt_w);
        end
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_back_to_back();
        test_hold();
        test_mid_reset();
        test_wide();
        step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/parity.md
PARITY -- requirements
Module: parity

Interface
REQ-001 Parameter WIDTH, default 4, data input width in bits (legal range 1..32).
REQ-002 Parameter ODD, default 0: 0 selects even-parity generation, 1 selects odd-parity generation.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port in, input, WIDTH bits: data word whose parity is computed.
REQ-006 Port out, output, 1 bit: registered parity bit for the word sampled on the previous rising edge.
REQ-007 Port ones_count, output, $clog2(WIDTH+1) bits: registered count of 1-bits in the sampled word.

Function
REQ-008 The block SHALL sample in on every rising clk edge while rst is low; there is no enable and no handshake.
REQ-009 With ODD=0, out SHALL equal the XOR-reduction of the sampled word: 1 when the word holds an odd number of 1-bits, else 0.
REQ-010 With ODD=1, out SHALL equal the inverse of the XOR-reduction.
REQ-011 ones_count SHALL equal the population count of the sampled word, zero-extended, with no overflow for any WIDTH.
REQ-012 Latency SHALL be exactly one clock: a value applied before edge N appears on out and ones_count after edge N.
REQ-013 Outputs SHALL hold their values between edges regardless of glitches on in.
REQ-014 Back-to-back changes of in on every cycle SHALL each produce a result; no input is dropped.
REQ-015 out SHALL always equal ones_count[0] XOR ODD; this invariant holds at every cycle, including after reset.
REQ-016 An X or Z bit on in is outside the contract; out and ones_count may then be unknown.

Reset
REQ-017 When rst is high at a rising edge, out SHALL become ODD and ones_count SHALL become 0, overriding the sampled data.
REQ-018 Assertion of rst in mid-stream SHALL discard the word sampled on that edge; the first result after rst falls SHALL correspond to the word sampled on the first edge with rst low.
REQ-019 Before the first clock edge, the output values are undefined; the block has no asynchronous behaviour.

Structure
REQ-020 A shared package parity_pkg SHALL hold PARITY_DEFAULT_WIDTH (4) and a function computing the count width ($clog2(WIDTH+1)).
REQ-021 A combinational sub-module parity_tree SHALL perform the XOR reduction and the population count for a parameterised WIDTH, as a balanced tree.
REQ-022 The top-level parity SHALL contain only the instance of parity_tree, the ODD inversion and the output registers.

Verification
REQ-023 Apply rst for 2 cycles with in=4'b1111 -> out=0 and ones_count=0 (ODD=0).
REQ-024 Release rst and sweep in from 4'b0000 to 4'b1111, one value per cycle. Each result appears one cycle later:
- 0000 -> out 0, count 0
- 0001 -> out 1, count 1
- 0011 -> out 0, count 2
- 0111 -> out 1, count 3
- 1111 -> out 0, count 4
REQ-025 With ODD=1, repeat the sweep -> out is inverted for every value: 0000 -> out 1, 1011 -> out 0.
REQ-026 Change in every cycle (1010, 0100, 1101) -> out sequence 0, 1, 1 with exactly one cycle of lag and no dropped values.
REQ-027 Assert rst for one cycle in mid-sweep with in=0111 -> that cycle yields out=ODD and count=0; the next word is processed normally.
REQ-028 With WIDTH=8, apply in=8'hFF and then 8'h80 -> counts 8 and 1, out 0 and 1; the invariant of REQ-015 is checked every cycle.
